// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT stage sequencer and its address helper.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int MAX_LOG2N = 10;
  localparam int TW_W      = 9;
  localparam int STAGE_W   = 4;

  // log2(N) for N = 8 << cfg
  function automatic logic [STAGE_W-1:0] cfg_to_stages(input logic [2:0] cfg);
    return STAGE_W'(cfg) + STAGE_W'(3);
  endfunction

endpackage

// File: rtl/fft_bfly_addr_calc.sv
// Radix-2 DIT butterfly addressing: maps (stage, butterfly index) to the
// in-place operand pair and the twiddle index into a 1024-entry table.
module fft_bfly_addr_calc
  import fft_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [STAGE_W-1:0] s,
  input  logic [ADDR_W-2:0]  k,
  output logic [ADDR_W-1:0]  top,
  output logic [ADDR_W-1:0]  bot,
  output logic [ADDR_W-2:0]  tw
);

  logic [ADDR_W-1:0] kx;
  logic [ADDR_W-1:0] half;
  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] top_w;
  logic [ADDR_W-1:0] tw_w;

  always_comb begin
    kx    = ADDR_W'(k);
    half  = ADDR_W'(1) << s;
    j     = kx & (half - ADDR_W'(1));
    // group base: drop the in-group bits of k, then leave room for the bottom half
    top_w = ((kx >> s) << (s + STAGE_W'(1))) | j;
    tw_w  = j << (STAGE_W'(ADDR_W - 1) - s);
    top   = top_w;
    bot   = top_w + half;
    tw    = tw_w[ADDR_W-2:0];
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Issues in-place radix-2 DIT butterflies stage by stage over a valid/ready
// stream, draining the datapath pipeline between stages.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int DELAY  = 6,
  parameter int CFG_W  = 3,
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               i_resetn,
  input  logic [CFG_W-1:0]   i_point_configuration,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_valid,
  output logic [ADDR_W-1:0]  o_top_addr,
  output logic [ADDR_W-1:0]  o_bot_addr,
  output logic [ADDR_W-2:0]  o_tw_idx,
  output logic [3:0]         o_stage,
  output logic               o_new_stage_trigger,
  output logic               o_last_in_stage,
  output logic               o_fft_done
);

  localparam int KW  = ADDR_W - 1;
  localparam int DCW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DELAY > 0) ? DELAY - 1 : 0);

  state_t             state, state_n;
  logic [STAGE_W-1:0] s, s_n, s_last, s_last_n;
  logic [KW-1:0]      k, k_n, k_last, k_last_n;
  logic [DCW-1:0]     dcnt, dcnt_n;
  logic               stage_end;
  logic               valid_n;
  logic [ADDR_W-1:0]  top_n, bot_n;
  logic [ADDR_W-2:0]  tw_n;

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state  <= ST_IDLE;
      s      <= '0;
      k      <= '0;
      s_last <= '0;
      k_last <= '0;
      dcnt   <= '0;
    end else begin
      state  <= state_n;
      s      <= s_n;
      k      <= k_n;
      s_last <= s_last_n;
      k_last <= k_last_n;
      dcnt   <= dcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    s_n       = s;
    k_n       = k;
    s_last_n  = s_last;
    k_last_n  = k_last;
    dcnt_n    = dcnt;
    stage_end = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_n  = ST_ISSUE;
          s_n      = '0;
          k_n      = '0;
          s_last_n = cfg_to_stages(3'(i_point_configuration)) - STAGE_W'(1);
          k_last_n = KW'((32'd4 << i_point_configuration) - 32'd1);
        end
      end
      ST_ISSUE: begin
        if (i_ready) begin
          if (k == k_last) begin
            dcnt_n = '0;
            if (DELAY == 0) stage_end = 1'b1;
            else            state_n   = ST_DRAIN;
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt == DRAIN_LAST) stage_end = 1'b1;
        else                    dcnt_n    = dcnt + DCW'(1);
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    if (stage_end) begin
      if (s == s_last) begin
        state_n = ST_DONE;
      end else begin
        state_n = ST_ISSUE;
        s_n     = s + STAGE_W'(1);
        k_n     = '0;
      end
    end

    if (i_abort) begin
      state_n = ST_IDLE;
      s_n     = '0;
      k_n     = '0;
      dcnt_n  = '0;
    end
  end

  assign valid_n = (state_n == ST_ISSUE);

  fft_bfly_addr_calc #(.ADDR_W(ADDR_W)) u_addr (
    .s   (s_n),
    .k   (k_n),
    .top (top_n),
    .bot (bot_n),
    .tw  (tw_n)
  );

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      o_busy              <= 1'b0;
      o_valid             <= 1'b0;
      o_top_addr          <= '0;
      o_bot_addr          <= '0;
      o_tw_idx            <= '0;
      o_stage             <= '0;
      o_new_stage_trigger <= 1'b0;
      o_last_in_stage     <= 1'b0;
      o_fft_done          <= 1'b0;
    end else begin
      o_busy              <= (state_n != ST_IDLE);
      o_valid             <= valid_n;
      o_top_addr          <= valid_n ? top_n : '0;
      o_bot_addr          <= valid_n ? bot_n : '0;
      o_tw_idx            <= valid_n ? tw_n  : '0;
      o_stage             <= (state_n == ST_IDLE) ? '0 : s_n;
      // pulse only when the stage's first butterfly is newly presented, not while stalled
      o_new_stage_trigger <= valid_n && (k_n == '0) && !((state == ST_ISSUE) && !i_ready);
      o_last_in_stage     <= valid_n && (k_n == k_last_n);
      o_fft_done          <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Randomised and directed bench comparing the sequencer against an arithmetic
// model of the radix-2 DIT butterfly schedule.
module tb_fft_stage_sequencer;
  localparam int DELAY  = 6;
  localparam int CFG_W  = 3;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              i_resetn;
  logic [CFG_W-1:0]  i_point_configuration;
  logic              i_start, i_abort, i_ready;
  logic              o_busy, o_valid, o_new_stage_trigger, o_last_in_stage, o_fft_done;
  logic [ADDR_W-1:0] o_top_addr, o_bot_addr;
  logic [ADDR_W-2:0] o_tw_idx;
  logic [3:0]        o_stage;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.DELAY(DELAY), .CFG_W(CFG_W), .ADDR_W(ADDR_W)) dut (
    .clk                   (clk),
    .i_resetn              (i_resetn),
    .i_point_configuration (i_point_configuration),
    .i_start               (i_start),
    .i_abort               (i_abort),
    .i_ready               (i_ready),
    .o_busy                (o_busy),
    .o_valid               (o_valid),
    .o_top_addr            (o_top_addr),
    .o_bot_addr            (o_bot_addr),
    .o_tw_idx              (o_tw_idx),
    .o_stage               (o_stage),
    .o_new_stage_trigger   (o_new_stage_trigger),
    .o_last_in_stage       (o_last_in_stage),
    .o_fft_done            (o_fft_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_valid"}, 32'(o_valid), 0);
    check({tag, "_top"},   32'(o_top_addr), 0);
    check({tag, "_bot"},   32'(o_bot_addr), 0);
    check({tag, "_tw"},    32'(o_tw_idx), 0);
    check({tag, "_stage"}, 32'(o_stage), 0);
    check({tag, "_trig"},  32'(o_new_stage_trigger), 0);
    check({tag, "_last"},  32'(o_last_in_stage), 0);
    check({tag, "_done"},  32'(o_fft_done), 0);
  endtask

  // Butterfly k of stage s: pairs sit half = 2^s apart inside groups of 2*half.
  function automatic void model_bfly(input int s, input int k, output int top, output int bot,
                                     output int tw);
    int half, g, j;
    half = 2 ** s;
    g    = k / half;
    j    = k % half;
    top  = g * 2 * half + j;
    bot  = top + half;
    tw   = j * (512 / half);
  endfunction

  // One FFT run. abort_s/abort_k, inj_c (stray start) and rst_c (reset cycle) are -1 when unused.
  task automatic run_fft(input int cfg, input bit rnd, input int abort_s, input int abort_k,
                         input int inj_c, input int rst_c);
    int S, B, total, idx, c, trig, shown, exp_done, budget, es, ek, et, eb, ew;
    S        = cfg + 3;
    B        = 4 << cfg;
    total    = S * B;
    exp_done = 1 + S * (B + DELAY);
    budget   = rnd ? 4 * exp_done + 50 : exp_done + 5;
    idx = 0; trig = 0; shown = -1;
    @(negedge clk);
    i_point_configuration = CFG_W'(cfg);
    i_start = 1'b1;
    i_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    c = 1;
    while (c <= budget) begin
      if (o_fft_done) break;
      if (c == rst_c) begin
        check("pre_reset_in_drain", 32'({o_busy, o_valid}), 32'b10);
        i_resetn = 1'b0;
        #1;
        check_quiet("async_reset");
        @(negedge clk);
        i_resetn = 1'b1;
        return;
      end
      check("busy_during_run", 32'(o_busy), 1);
      es = idx / B;
      ek = idx % B;
      if (o_valid) begin
        if (idx >= total) begin
          check("extra_butterfly", idx, total);
        end else begin
          model_bfly(es, ek, et, eb, ew);
          check("top",   32'(o_top_addr), et);
          check("bot",   32'(o_bot_addr), eb);
          check("tw",    32'(o_tw_idx), ew);
          check("stage", 32'(o_stage), es);
          check("last",  32'(o_last_in_stage), 32'(ek == B - 1));
          check("trig",  32'(o_new_stage_trigger), 32'(ek == 0 && shown != idx));
        end
        if (o_new_stage_trigger) trig++;
        shown = idx;
        if (es == abort_s && ek == abort_k) begin
          i_abort = 1'b1;
          @(negedge clk);
          i_abort = 1'b0;
          check_quiet("after_abort");
          @(negedge clk);
          check("no_done_after_abort", 32'({o_fft_done, o_busy}), 0);
          return;
        end
      end else begin
        check("trig_when_idle_bus", 32'(o_new_stage_trigger), 0);
      end
      if (c == inj_c) begin
        i_start = 1'b1;
        i_point_configuration = CFG_W'(5);
      end else begin
        i_start = 1'b0;
      end
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_valid && i_ready) idx++;
      @(negedge clk);
      c++;
    end
    check("done_seen", 32'(o_fft_done), 1);
    if (!rnd) check("done_cycle", c, exp_done);
    check("handshakes", idx, total);
    check("stage_triggers", trig, S);
    check("busy_at_done", 32'(o_busy), 1);
    check("valid_at_done", 32'(o_valid), 0);
    i_ready = 1'b1;
    @(negedge clk);
    check_quiet("after_done");
  endtask

  initial begin
    i_resetn = 1'b0;
    i_point_configuration = '0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    i_resetn = 1'b1;

    // 8-point run, then the full 1024-point run
    run_fft(0, 1'b0, -1, -1, -1, -1);
    run_fft(7, 1'b0, -1, -1, -1, -1);

    // back-pressured 32-point run
    run_fft(2, 1'b1, -1, -1, -1, -1);

    // abort in stage 1 at k=5, then a clean 16-point run
    run_fft(2, 1'b0, 1, 5, -1, -1);
    run_fft(1, 1'b0, -1, -1, -1, -1);

    // start together with abort from idle is not honoured
    @(negedge clk);
    i_start = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    check_quiet("start_with_abort");

    // stray start with cfg=5 during an 8-point run
    run_fft(0, 1'b0, -1, -1, 3, -1);

    // reset during stage 0 drain, then a clean run
    run_fft(0, 1'b0, -1, -1, -1, 7);
    run_fft(0, 1'b0, -1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences the in-place radix-2 DIT FFT datapath over the configured point size.
- For every stage it issues one butterfly per accepted cycle: top/bottom SRAM addresses and a twiddle index into a 1024-entry table.
- After each stage it waits for the datapath pipeline to drain, then signals completion.
- Sits between the FFT top-level control (start/abort) and the butterfly/SRAM datapath, which consumes the valid/ready stream.

Parameters:
- DELAY, 6, datapath latency in cycles; drain wait inserted after each stage.
- CFG_W, 3, width of the point-configuration field.
- ADDR_W, 10, SRAM address width; max N = 2^ADDR_W = 1024.

Ports:
- clk  in  1  clock.
- i_resetn  in  1  asynchronous active-low reset.
- i_point_configuration  in  CFG_W  size select: N = 8 << cfg (0→8 … 7→1024). Sampled only on an accepted start.
- i_start  in  1  start pulse; honoured only in IDLE.
- i_abort  in  1  abort; returns to IDLE from any state.
- i_ready  in  1  datapath accepts current butterfly.
- o_busy  out  1  high from the cycle after an accepted start through the o_done cycle inclusive.
- o_valid  out  1  butterfly outputs valid.
- o_top_addr  out  ADDR_W  top operand address.
- o_bot_addr  out  ADDR_W  bottom operand address.
- o_tw_idx  out  ADDR_W-1  twiddle index (1024-pt table).
- o_stage  out  4  current stage number.
- o_new_stage_trigger  out  1  one-cycle pulse on the first valid butterfly of every stage, including stage 0.
- o_last_in_stage  out  1  high with o_valid on the stage's final butterfly.
- o_fft_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE→ISSUE on i_start && !i_abort.
  - Latch S = cfg+3 and B = N/2 = 4<<cfg.
  - Clear stage counter s and butterfly counter k (9 bits).
- ISSUE: o_valid=1.
  - Address arithmetic, with half = 1<<s:
    - j = k & (half-1)
    - top = ((k>>s)<<(s+1)) | j
    - bot = top + half
    - tw = j << (ADDR_W-1-s)
  - All arithmetic is unsigned; no overflow is possible for legal cfg.
  - Registered outputs: the start accepted at cycle t gives the first butterfly at t+1.
  - Handshake: k advances only when o_valid && i_ready. While i_ready=0 all outputs hold stable.
  - On acceptance with k==B-1: ISSUE→DRAIN, reset drain counter.
- DRAIN: o_valid=0 for exactly DELAY cycles. Then:
  - if s==S-1 → DONE;
  - else s++, k=0, → ISSUE.
- DONE: o_fft_done=1 for one cycle, o_busy=1; next cycle IDLE with o_busy=0.
- Timing with i_ready held 1:
  - each stage occupies B+DELAY cycles;
  - o_fft_done at t+1+S*(B+DELAY).
- Boundary rules:
  - i_start while not IDLE: ignored; cfg is not re-sampled.
  - i_abort (any state, incl. concurrent with i_start): next cycle IDLE, all outputs 0, no o_fft_done.
  - i_ready=0 on the last butterfly: stays in ISSUE, o_last_in_stage held.
  - DELAY=0 is legal: DRAIN lasts zero cycles; the next stage starts the cycle after the last acceptance.
  - Reset mid-run: immediate return to reset values.

Decomposition:
- Package fft_ctrl_pkg holds:
  - state enum;
  - MAX_LOG2N=10 and TW_W=9 constants;
  - function cfg_to_stages(cfg).
- Sub-module fft_bfly_addr_calc: purely combinational (s, k) → (top, bot, tw). It is reusable by the bench as a reference model.

Test Plan:
- cfg=0, i_ready=1, DELAY=6, start at t:
  - stage0 pairs (0,1)(2,3)(4,5)(6,7), tw 0;
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,256,0,256;
  - stage2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,128,256,384;
  - o_fft_done at t+31.
- cfg=7, i_ready=1:
  - 10 stages of 512 butterflies;
  - stage9 last butterfly is (511,1023), tw 511;
  - o_new_stage_trigger pulses 10 times;
  - done at t+5181.
- cfg=2, i_ready toggling 1/0 randomly:
  - outputs hold while i_ready=0;
  - sequence identical to the i_ready=1 run;
  - exactly 5*16 handshakes.
- Mid-stage abort at cfg=2 (stage1, k=5):
  - next cycle o_valid=0, o_busy=0, no done;
  - a new start with cfg=1 gives the first butterfly (0,1), stage 0, N=16 schedule.
- i_start pulsed with cfg=5 while busy on cfg=0:
  - ignored; run completes as 8-point at t+31.
- Async reset asserted during DRAIN, released:
  - all outputs 0 immediately;
  - subsequent start runs cleanly.
